// File: rtl/bolme_hakemi_pkg.sv
// Shared types and constants for the two-requester divider controller.
package bolme_paketi;

  // RISC-V M-extension divide operation codes as carried on the issue ports.
  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } islem_t;

  // Controller states.
  typedef enum logic [1:0] {
    BOS    = 2'b00,
    BASLAT = 2'b01,
    BEKLE  = 2'b10,
    YANIT  = 2'b11
  } durum_t;

  localparam logic [31:0] EN_KUCUK_ISARETLI = 32'h8000_0000;
  localparam logic [31:0] EKSI_BIR          = 32'hFFFF_FFFF;

  // One-entry result cache: operand pair, signedness and both divider outputs.
  typedef struct packed {
    logic        gecerli;
    logic [31:0] a;
    logic [31:0] b;
    logic        isaretli;
    logic [31:0] bolum;
    logic [31:0] kalan;
  } onbellek_t;

  // Signed INT_MIN / -1 is the only divide whose quotient does not fit.
  function automatic logic tasma_mi(input logic isaretli,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    return isaretli && (a == EN_KUCUK_ISARETLI) && (b == EKSI_BIR);
  endfunction

endpackage

// File: rtl/bolme_hakemi_hakem.sv
// Two-input round-robin arbiter; the pointer moves to the loser after each grant.
module iki_girisli_hakem (
  input  logic clk,
  input  logic rst_g,
  input  logic istek0_i,
  input  logic istek1_i,
  input  logic ilerlet_i,
  output logic izin0_o,
  output logic izin1_o
);

  logic isaretci_q;
  logic isaretci_d;

  // Grant: a lone requester wins, a tie goes to the port named by the pointer.
  always_comb begin
    izin0_o    = ilerlet_i & istek0_i & (~istek1_i | ~isaretci_q);
    izin1_o    = ilerlet_i & istek1_i & (~istek0_i |  isaretci_q);
    isaretci_d = isaretci_q;
    if (izin0_o) begin
      isaretci_d = 1'b1;
    end else if (izin1_o) begin
      isaretci_d = 1'b0;
    end
  end

  // Priority pointer register, port 0 favoured out of reset.
  always_ff @(posedge clk or posedge rst_g) begin
    if (rst_g) begin
      isaretci_q <= 1'b0;
    end else begin
      isaretci_q <= isaretci_d;
    end
  end

endmodule

// File: rtl/bolme_hakemi.sv
// Shares one iterative divider between two issue ports, with a one-entry
// result cache so a REM after a DIV on the same operands skips the divider.
module bolme_hakemi
  import bolme_paketi::*;
#(
  parameter bit ONBELLEK_AKTIF = 1'b1
) (
  input  logic        clk,
  input  logic        rst_g,
  input  logic        i0_istek,
  input  logic [31:0] i0_a,
  input  logic [31:0] i0_b,
  input  logic [1:0]  i0_islem,
  output logic        i0_kabul,
  output logic        i0_yanit_gecerli,
  output logic [31:0] i0_sonuc,
  input  logic        i1_istek,
  input  logic [31:0] i1_a,
  input  logic [31:0] i1_b,
  input  logic [1:0]  i1_islem,
  output logic        i1_kabul,
  output logic        i1_yanit_gecerli,
  output logic [31:0] i1_sonuc,
  output logic        mesgul,
  output logic        bl_istek,
  output logic [31:0] bl_a,
  output logic [31:0] bl_b,
  output logic        bl_isaretli,
  output logic        bl_overflow,
  output logic        bl_divbyzero,
  input  logic [31:0] bl_bolum,
  input  logic [31:0] bl_kalan,
  input  logic        bl_bitti
);

  durum_t      durum_q, durum_d;
  logic [31:0] a_q, b_q, bolum_q, kalan_q;
  logic        kalan_sec_q, sahip_q, isaretli_q, tasma_q, sifir_q;
  onbellek_t   onb_q;

  logic        izin0, izin1, verildi, isabet, sec_isaretli, bitti_al;
  logic [31:0] sec_a, sec_b, secilen;
  logic [1:0]  sec_islem;

  iki_girisli_hakem u_hakem (
    .clk       (clk),
    .rst_g     (rst_g),
    .istek0_i  (i0_istek),
    .istek1_i  (i1_istek),
    .ilerlet_i (durum_q == BOS),
    .izin0_o   (izin0),
    .izin1_o   (izin1)
  );

  // Winning port's operands and the cache lookup made in the grant cycle.
  always_comb begin
    verildi      = izin0 | izin1;
    sec_a        = izin1 ? i1_a     : i0_a;
    sec_b        = izin1 ? i1_b     : i0_b;
    sec_islem    = izin1 ? i1_islem : i0_islem;
    sec_isaretli = ~sec_islem[0];
    isabet       = ONBELLEK_AKTIF && onb_q.gecerli &&
                   (onb_q.a == sec_a) && (onb_q.b == sec_b) &&
                   (onb_q.isaretli == sec_isaretli);
    bitti_al     = (durum_q == BEKLE) && bl_bitti;
  end

  // Next state and the divider start pulse.
  always_comb begin
    durum_d  = durum_q;
    bl_istek = 1'b0;
    unique case (durum_q)
      BOS:     if (verildi) durum_d = isabet ? YANIT : BASLAT;
      BASLAT:  begin bl_istek = 1'b1; durum_d = BEKLE; end
      BEKLE:   if (bl_bitti) durum_d = YANIT;
      YANIT:   durum_d = BOS;
      default: durum_d = BOS;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst_g) begin
    if (rst_g) begin
      durum_q <= BOS;
    end else begin
      durum_q <= durum_d;
    end
  end

  // Operand/side-input latch on grant; result from the cache on a hit or from the divider on done.
  always_ff @(posedge clk or posedge rst_g) begin
    if (rst_g) begin
      a_q         <= '0;
      b_q         <= '0;
      kalan_sec_q <= 1'b0;
      sahip_q     <= 1'b0;
      isaretli_q  <= 1'b0;
      tasma_q     <= 1'b0;
      sifir_q     <= 1'b0;
      bolum_q     <= '0;
      kalan_q     <= '0;
    end else if (verildi) begin
      a_q         <= sec_a;
      b_q         <= sec_b;
      kalan_sec_q <= sec_islem[1];
      sahip_q     <= izin1;
      isaretli_q  <= sec_isaretli;
      tasma_q     <= tasma_mi(sec_isaretli, sec_a, sec_b);
      sifir_q     <= (sec_b == '0);
      if (isabet) begin
        bolum_q <= onb_q.bolum;
        kalan_q <= onb_q.kalan;
      end
    end else if (bitti_al) begin
      bolum_q <= bl_bolum;
      kalan_q <= bl_kalan;
    end
  end

  // Cache fill on every completed division; reset invalidates it.
  always_ff @(posedge clk or posedge rst_g) begin
    if (rst_g) begin
      onb_q <= '0;
    end else if (bitti_al) begin
      onb_q <= '{gecerli: 1'b1, a: a_q, b: b_q, isaretli: isaretli_q,
                 bolum: bl_bolum, kalan: bl_kalan};
    end
  end

  // Port-facing outputs; the result goes only to the owner port.
  always_comb begin
    i0_kabul         = izin0;
    i1_kabul         = izin1;
    mesgul           = (durum_q != BOS);
    secilen          = kalan_sec_q ? kalan_q : bolum_q;
    i0_yanit_gecerli = (durum_q == YANIT) & ~sahip_q;
    i1_yanit_gecerli = (durum_q == YANIT) &  sahip_q;
    i0_sonuc         = i0_yanit_gecerli ? secilen : '0;
    i1_sonuc         = i1_yanit_gecerli ? secilen : '0;
    bl_a             = a_q;
    bl_b             = b_q;
    bl_isaretli      = isaretli_q;
    bl_overflow      = tasma_q;
    bl_divbyzero     = sifir_q;
  end

endmodule

// File: tb/tb_bolme_hakemi.sv
// Directed bench for bolme_hakemi with a behavioural radix-4 divider beside it.
module tb_bolme_hakemi;

  logic        clk, rst_g;
  logic        i0_istek, i1_istek;
  logic [31:0] i0_a, i0_b, i1_a, i1_b;
  logic [1:0]  i0_islem, i1_islem;
  logic        i0_kabul, i1_kabul, i0_yanit_gecerli, i1_yanit_gecerli;
  logic [31:0] i0_sonuc, i1_sonuc;
  logic        mesgul, bl_istek, bl_isaretli, bl_overflow, bl_divbyzero;
  logic [31:0] bl_a, bl_b, bl_bolum, bl_kalan;
  logic        bl_bitti, bitti_ek;
  logic [4:0]  dcnt;

  int checks = 0;
  int errors = 0;

  bolme_hakemi #(.ONBELLEK_AKTIF(1'b1)) dut (
    .clk(clk), .rst_g(rst_g),
    .i0_istek(i0_istek), .i0_a(i0_a), .i0_b(i0_b), .i0_islem(i0_islem),
    .i0_kabul(i0_kabul), .i0_yanit_gecerli(i0_yanit_gecerli), .i0_sonuc(i0_sonuc),
    .i1_istek(i1_istek), .i1_a(i1_a), .i1_b(i1_b), .i1_islem(i1_islem),
    .i1_kabul(i1_kabul), .i1_yanit_gecerli(i1_yanit_gecerli), .i1_sonuc(i1_sonuc),
    .mesgul(mesgul), .bl_istek(bl_istek), .bl_a(bl_a), .bl_b(bl_b),
    .bl_isaretli(bl_isaretli), .bl_overflow(bl_overflow), .bl_divbyzero(bl_divbyzero),
    .bl_bolum(bl_bolum), .bl_kalan(bl_kalan), .bl_bitti(bl_bitti)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider stand-in: start pulse at t+1, done strobe 18 cycles later (t+19).
  always @(posedge clk or posedge rst_g) begin
    if (rst_g) dcnt <= '0;
    else if (bl_istek) dcnt <= 5'd18;
    else if (dcnt != 0) dcnt <= dcnt - 5'd1;
  end
  assign bl_bitti = (dcnt == 5'd1) | bitti_ek;

  // Divider outputs follow RISC-V rules but only honour the special cases
  // when the side inputs say so; otherwise they return a poison value.
  function automatic logic [63:0] bolucu(input logic [31:0] a, b,
                                         input logic s, ovf, dbz);
    logic [31:0] q, r;
    if (dbz) begin q = 32'hFFFF_FFFF; r = a; end
    else if (ovf) begin q = a; r = 32'h0; end
    else if (b == 0) begin q = 32'h0BAD_0BAD; r = q; end
    else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin q = 32'hDEAD_BEEF; r = q; end
    else if (s) begin q = 32'($signed(a) / $signed(b)); r = 32'($signed(a) % $signed(b)); end
    else begin q = a / b; r = a % b; end
    return {q, r};
  endfunction

  always_comb begin
    {bl_bolum, bl_kalan} = bolucu(bl_a, bl_b, bl_isaretli, bl_overflow, bl_divbyzero);
  end

  task automatic chk(input string tag, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    checks++;
    assert (gozlenen === beklenen) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, gozlenen, beklenen);
    end
  endtask

  function automatic logic strobe_of(input int p);
    return (p == 0) ? i0_yanit_gecerli : i1_yanit_gecerli;
  endfunction

  task automatic surucu(input int p, input logic v, input logic [31:0] a, b, input logic [1:0] op);
    if (p == 0) begin i0_istek = v; i0_a = a; i0_b = b; i0_islem = op; end
    else        begin i1_istek = v; i1_a = a; i1_b = b; i1_islem = op; end
  endtask

  // Called at the negedge of t+1; returns the cycle offset of the strobe.
  task automatic bekle(input int p, output int n, output bit yan, output bit istek_gor);
    n = 1; yan = 1'b0; istek_gor = bl_istek;
    while (!strobe_of(p) && n < 40) begin
      if (strobe_of(1 - p)) yan = 1'b1;
      @(negedge clk); #1;
      n++;
      if (bl_istek) istek_gor = 1'b1;
    end
    if (strobe_of(1 - p)) yan = 1'b1;
  endtask

  task automatic run_op(input int p, input logic [31:0] a, b, input logic [1:0] op,
                        input logic [31:0] beklenen, input bit isabet, input string tag);
    int n; bit yan, istek_gor;
    @(negedge clk);
    surucu(p, 1'b1, a, b, op);
    #1;
    chk({tag, "_kabul"}, (p == 0) ? i0_kabul : i1_kabul, 32'd1);
    @(negedge clk);
    surucu(p, 1'b0, a, b, op);
    #1;
    chk({tag, "_mesgul"}, mesgul, 32'd1);
    bekle(p, n, yan, istek_gor);
    chk({tag, "_gecikme"}, n, isabet ? 32'd1 : 32'd20);
    chk({tag, "_sonuc"}, (p == 0) ? i0_sonuc : i1_sonuc, beklenen);
    chk({tag, "_digersonuc"}, (p == 0) ? i1_sonuc : i0_sonuc, 32'd0);
    chk({tag, "_blistek"}, istek_gor, isabet ? 32'd0 : 32'd1);
    chk({tag, "_yanstrobe"}, yan, 32'd0);
  endtask

  initial begin
    int n; bit yan, istek_gor, herhangi;
    rst_g = 1'b1; bitti_ek = 1'b0;
    surucu(0, 1'b0, 32'd0, 32'd0, 2'b00);
    surucu(1, 1'b0, 32'd0, 32'd0, 2'b00);
    @(negedge clk); @(negedge clk);
    chk("rst_mesgul", mesgul, 32'd0);
    chk("rst_blistek", bl_istek, 32'd0);
    chk("rst_bl_ops", {bl_a ^ bl_b}, 32'd0);
    chk("rst_bl_side", {bl_isaretli, bl_overflow, bl_divbyzero}, 32'd0);
    chk("rst_strobes", {i0_yanit_gecerli, i1_yanit_gecerli, i0_kabul, i1_kabul}, 32'd0);
    chk("rst_sonuc", i0_sonuc | i1_sonuc, 32'd0);
    rst_g = 1'b0;

    run_op(0, 32'd100, 32'd7, 2'b00, 32'd14, 1'b0, "div100_7");
    run_op(0, 32'd100, 32'd7, 2'b10, 32'd2, 1'b1, "rem100_7");
    run_op(1, 32'hFFFF_FFF9, 32'd2, 2'b01, 32'h7FFF_FFFC, 1'b0, "divu_m7");
    run_op(1, 32'hFFFF_FFF9, 32'd2, 2'b00, 32'hFFFF_FFFD, 1'b0, "div_m7");
    run_op(0, 32'hFFFF_FFF9, 32'd2, 2'b10, 32'hFFFF_FFFF, 1'b1, "rem_m7");
    run_op(0, 32'h1234, 32'd0, 2'b11, 32'h1234, 1'b0, "remu_z");
    run_op(1, 32'd5, 32'd0, 2'b00, 32'hFFFF_FFFF, 1'b0, "div_z");
    run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'h8000_0000, 1'b0, "div_ovf");
    run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 32'h0, 1'b1, "rem_ovf");

    // Stray done strobe while idle must not wake the controller.
    @(negedge clk); bitti_ek = 1'b1;
    @(negedge clk); bitti_ek = 1'b0; #1;
    chk("stray_bitti_mesgul", mesgul, 32'd0);
    chk("stray_bitti_strobe", {i0_yanit_gecerli, i1_yanit_gecerli}, 32'd0);

    // Simultaneous requests after a fresh reset.
    @(negedge clk); rst_g = 1'b1; @(negedge clk); rst_g = 1'b0;
    @(negedge clk);
    surucu(0, 1'b1, 32'd50, 32'd5, 2'b01);
    surucu(1, 1'b1, 32'd9, 32'd4, 2'b11);
    #1;
    chk("pair1_i0_kabul", i0_kabul, 32'd1);
    chk("pair1_i1_kabul", i1_kabul, 32'd0);
    @(negedge clk); surucu(0, 1'b0, 32'd50, 32'd5, 2'b01); #1;
    bekle(0, n, yan, istek_gor);
    chk("pair1_i0_gecikme", n, 32'd20);
    chk("pair1_i0_sonuc", i0_sonuc, 32'd10);
    chk("pair1_i0_yan", yan, 32'd0);
    chk("pair1_i1_kabul_yanit", i1_kabul, 32'd0);
    @(negedge clk); #1;
    chk("pair1_i1_kabul_sonra", i1_kabul, 32'd1);
    @(negedge clk); surucu(1, 1'b0, 32'd9, 32'd4, 2'b11); #1;
    bekle(1, n, yan, istek_gor);
    chk("pair1_i1_gecikme", n, 32'd20);
    chk("pair1_i1_sonuc", i1_sonuc, 32'd1);
    chk("pair1_i1_yan", yan, 32'd0);

    @(negedge clk);
    surucu(0, 1'b1, 32'd60, 32'd7, 2'b01);
    surucu(1, 1'b1, 32'd9, 32'd4, 2'b11);
    #1;
    chk("pair2_i0_kabul", i0_kabul, 32'd1);
    chk("pair2_i1_kabul", i1_kabul, 32'd0);
    @(negedge clk); surucu(0, 1'b0, 32'd60, 32'd7, 2'b01); #1;
    bekle(0, n, yan, istek_gor);
    chk("pair2_i0_sonuc", i0_sonuc, 32'd8);
    chk("pair2_i0_yan", yan, 32'd0);
    @(negedge clk); #1;
    chk("pair2_i1_kabul", i1_kabul, 32'd1);
    @(negedge clk); surucu(1, 1'b0, 32'd9, 32'd4, 2'b11); #1;
    bekle(1, n, yan, istek_gor);
    chk("pair2_i1_gecikme", n, 32'd20);
    chk("pair2_i1_sonuc", i1_sonuc, 32'd1);

    // Fill the cache, then reset in the middle of a different division.
    run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'h8000_0000, 1'b0, "pre_ovf");
    @(negedge clk);
    surucu(0, 1'b1, 32'd1000, 32'd10, 2'b01);
    #1; chk("rstmid_kabul", i0_kabul, 32'd1);
    @(negedge clk); surucu(0, 1'b0, 32'd1000, 32'd10, 2'b01);
    repeat (9) @(negedge clk);
    rst_g = 1'b1; #1;
    chk("rstmid_mesgul", mesgul, 32'd0);
    chk("rstmid_bl_a", bl_a, 32'd0);
    chk("rstmid_bl_side", {bl_istek, bl_isaretli, bl_overflow, bl_divbyzero}, 32'd0);
    chk("rstmid_sonuc", i0_sonuc | i1_sonuc, 32'd0);
    @(negedge clk); rst_g = 1'b0;
    herhangi = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (i0_yanit_gecerli || i1_yanit_gecerli || mesgul) herhangi = 1'b1;
    end
    chk("rstmid_no_yanit", herhangi, 32'd0);
    run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 32'h0, 1'b0, "post_rst_rem");
    run_op(1, 32'd1000, 32'd10, 2'b01, 32'd100, 1'b0, "post_rst_divu");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bolme_hakemi.md
# bolme_hakemi

Two-requester controller for the shared radix-4 (two bits per cycle) iterative divider. It arbitrates round-robin between two issue ports and decodes RISC-V DIV/DIVU/REM/REMU. It computes the divider's `overflow`/`divbyzero` side inputs, starts the divider and holds its operands stable until `bitti`, then returns the selected result to the owning port. A one-entry result cache answers a repeated operand pair, such as a REM following a DIV, in one cycle without starting the divider. The divider instance sits beside this block at the execute-stage top level and is wired only to the `bl_*` ports.

## Interface
Parameters:
- `ONBELLEK_AKTIF`, default 1: enables the one-entry result cache. When 0, every request misses.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_g` in 1: asynchronous, active-high reset.
- `i0_istek` / `i1_istek` in 1: request; held by the requester until `kabul`.
- `i0_a`, `i0_b` / `i1_a`, `i1_b` in 32: dividend, divisor.
- `i0_islem` / `i1_islem` in 2: operation; 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `i0_kabul` / `i1_kabul` out 1: one-cycle accept pulse (Mealy, in BOS).
- `i0_yanit_gecerli` / `i1_yanit_gecerli` out 1: one-cycle result strobe; no backpressure.
- `i0_sonuc` / `i1_sonuc` out 32: result, valid while the strobe is high, otherwise 0.
- `mesgul` out 1: high in every state except BOS.
- `bl_istek` out 1: divider start pulse.
- `bl_a`, `bl_b` out 32: divider operands.
- `bl_isaretli`, `bl_overflow`, `bl_divbyzero` out 1: divider side inputs.
- `bl_bolum`, `bl_kalan` in 32: divider quotient and remainder.
- `bl_bitti` in 1: divider done strobe.

## Operation
- State machine:
  - BOS, idle: grants one request.
  - BASLAT: drives `bl_istek`=1 for exactly one cycle.
  - BEKLE: waits for `bl_bitti`.
  - YANIT: returns the result, then goes back to BOS.
- Arbitration: only in BOS. A single requester wins immediately. When both request, the port named by the 1-bit pointer wins. After any grant the pointer points to the other port. Reset sets the pointer to port 0.
- On grant, latch `a`, `b`, `islem` and the owner id:
  - `isaretli` = ~`islem`[0].
  - `divbyzero` = (`b` == 0).
  - `overflow` = `isaretli` & `a` == 32'h8000_0000 & `b` == 32'hFFFF_FFFF.
- `bl_a`, `bl_b`, `bl_isaretli`, `bl_overflow` and `bl_divbyzero` come from the latched registers. They stay constant from BASLAT through BEKLE, because the divider samples them again in its final cycle.
- Cache entry holds {valid, a, b, isaretli, bolum, kalan}.
  - Hit: valid & equal a, b and isaretli, checked in the grant cycle. A hit goes BOS→YANIT and never asserts `bl_istek`.
  - Miss: BOS→BASLAT→BEKLE.
- On `bl_bitti` in BEKLE: capture `bl_bolum`/`bl_kalan` into the result and cache registers, set cache valid, go to YANIT.
- Result selection: `islem`[1] ? kalan : bolum. Drive it only to the owner port. The other port's strobe and sonuc stay 0.
- `bl_bitti` outside BEKLE is ignored.
- Reset values: all outputs 0, state BOS, cache invalid, pointer 0.

## Timing
- Accept cycle t has `kabul`=1.
  - Hit: YANIT at t+1.
  - Miss: `bl_istek` at t+1. The divider iterates t+2..t+17, finalises at t+18 and raises `bl_bitti` at t+19. YANIT is at t+20.
- The next grant is possible at the cycle after YANIT, i.e. t+2 for a hit and t+21 for a miss.
- A request arriving while `mesgul` is waited on. `kabul` is never given outside BOS.
- Asynchronous reset mid-division:
  - Outputs clear immediately and no `yanit` is produced for the in-flight operation.
  - The divider is cleared by the same `rst_g` at the next edge.
  - The cache is invalid, so a re-issued request recomputes.
- A requester that drops `istek` before `kabul` is simply not served. No state is kept for it.

## Structure
- Package `bolme_paketi` holds:
  - operation codes DIV/DIVU/REM/REMU;
  - the state enum BOS/BASLAT/BEKLE/YANIT;
  - constants EN_KUCUK_ISARETLI = 32'h8000_0000 and EKSI_BIR = 32'hFFFF_FFFF.
- One natural sub-module: `iki_girisli_hakem`, the round-robin grant plus pointer register, advanced by a grant-enable input.
- The divider is not instantiated inside this block.

## Test plan
- i0 DIV a=100 b=7 → `i0_kabul` at t, `i0_sonuc`=14 at t+20. Then REM with the same operands → hit, `i0_sonuc`=2 one cycle after accept, `bl_istek` stays 0.
- DIVU a=32'hFFFF_FFF9 b=2 → 32'h7FFF_FFFC. Then DIV with the same operands misses (signedness differs) → 32'hFFFF_FFFD. Then REM hits → 32'hFFFF_FFFF.
- REMU a=32'h1234 b=0 → 32'h1234. DIV a=5 b=0 → 32'hFFFF_FFFF.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF → 32'h8000_0000. REM with the same operands → 0.
- i0 and i1 request together after reset → i0 granted first; i1 granted in the cycle after i0's YANIT. A simultaneous pair after that grants i0 again, since the pointer moved after the i1 grant. No strobe ever appears on the non-owner port.
- `rst_g` pulsed at t+10 of a miss → all outputs 0 at once, no `yanit` for that request. Re-issuing it yields the correct result at +20 cycles.
